// File: rtl/request_encoder.sv
// request_encoder: sequential N-to-IW encoder (N = 2**IW request lines).
// Collects one-cycle request pulses into a pending register and hands them
// out one index at a time over a valid/ready handshake.
// Optional macro ROUND_ROBIN_EN: rotating priority based on the last accepted
// index. Without it, the lowest pending index always wins.
module request_encoder #(
    parameter int IW = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [2**IW-1:0]     req_in,
    output logic [IW-1:0]        out_idx,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [IW:0]          pend_count
);

    localparam int N = 2**IW;

    logic [N-1:0]  pending_reg;
    logic [N-1:0]  pending_next;
    logic [IW-1:0] out_idx_reg;
    logic [IW-1:0] out_idx_next;
    logic          out_valid_reg;
    logic          out_valid_next;
    logic [IW:0]   pend_count_reg;
    logic [IW:0]   pend_count_next;

    logic [N-1:0]  idx_onehot;
    logic [N-1:0]  cand;
    logic          cand_any;
    logic [IW-1:0] sel;
    logic          accept;

`ifdef ROUND_ROBIN_EN
    logic [IW-1:0]  last_reg;
    logic [IW-1:0]  last_next;
    logic [IW-1:0]  scan_start;
    logic [2*N-1:0] cand_dbl;
    logic [N-1:0]   cand_rot;
    logic [IW-1:0]  rot_off;
`endif

    // Decode the presented index into a one-hot mask.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_onehot
            assign idx_onehot[gi] = (out_idx_reg == IW'(gi));
        end
    endgenerate

    assign accept   = out_valid_reg & out_ready;
    // The presented index is never re-selected while it is being offered.
    assign cand     = out_valid_reg ? (pending_reg & ~idx_onehot) : pending_reg;
    assign cand_any = |cand;

`ifdef ROUND_ROBIN_EN
    // Rotating priority: scan from last+1 upward, wrapping, last index scanned last.
    always_comb begin
        scan_start = last_reg + 1'b1;
        cand_dbl   = {cand, cand} >> scan_start;
        cand_rot   = cand_dbl[N-1:0];
        rot_off    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (cand_rot[i]) begin
                rot_off = IW'(i);
            end
        end
        sel       = rot_off + scan_start;
        last_next = accept ? out_idx_reg : last_reg;
    end
`else
    // Fixed priority: lowest set index of the candidate set.
    always_comb begin
        sel = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (cand[i]) begin
                sel = IW'(i);
            end
        end
    end
`endif

    // Pending capture, output register update and population count.
    always_comb begin
        pending_next   = (pending_reg & ~(accept ? idx_onehot : '0)) | req_in;
        out_idx_next   = out_idx_reg;
        out_valid_next = out_valid_reg;
        if (!out_valid_reg || accept) begin
            if (cand_any) begin
                out_idx_next   = sel;
                out_valid_next = 1'b1;
            end else begin
                out_valid_next = 1'b0;
            end
        end
        pend_count_next = '0;
        for (int i = 0; i < N; i++) begin
            pend_count_next = pend_count_next + {{IW{1'b0}}, pending_next[i]};
        end
    end

    // State registers; reset dominates, discarding any accept in that cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending_reg    <= '0;
            out_idx_reg    <= '0;
            out_valid_reg  <= 1'b0;
            pend_count_reg <= '0;
        end else begin
            pending_reg    <= pending_next;
            out_idx_reg    <= out_idx_next;
            out_valid_reg  <= out_valid_next;
            pend_count_reg <= pend_count_next;
        end
    end

`ifdef ROUND_ROBIN_EN
    // Last-grant pointer, updated on every accepted index.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_reg <= '0;
        end else begin
            last_reg <= last_next;
        end
    end
`endif

    assign out_idx    = out_idx_reg;
    assign out_valid  = out_valid_reg;
    assign pend_count = pend_count_reg;

endmodule

// File: tb/tb_request_encoder.sv
// Testbench for request_encoder: table of per-cycle vectors plus hand-written
// sequences for idle-after-reset and backpressure.
module tb_request_encoder;

    logic        clock;
    logic        reset;
    logic [31:0] req_in;
    logic [4:0]  out_idx;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  pend_count;

    int checks;
    int errors;

    typedef struct {
        logic        rst;
        logic [31:0] req;
        logic        rdy;
        logic        exp_valid;
        logic [4:0]  exp_idx;
        logic [5:0]  exp_count;
    } vec_t;

    vec_t vecs[$];

    request_encoder #(.IW(5)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_in     (req_in),
        .out_idx    (out_idx),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .pend_count (pend_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic add(input logic rst, input logic [31:0] req, input logic rdy,
                       input logic v, input logic [4:0] idx, input logic [5:0] cnt);
        vec_t e;
        e.rst = rst; e.req = req; e.rdy = rdy;
        e.exp_valid = v; e.exp_idx = idx; e.exp_count = cnt;
        vecs.push_back(e);
    endtask

    task automatic check(input string name, input int step,
                         input logic v, input logic [4:0] idx, input logic [5:0] cnt);
        checks++;
        if (out_valid !== v) begin
            errors++;
            $display("FAIL %s[%0d] out_valid got %b want %b", name, step, out_valid, v);
        end
        checks++;
        if (out_idx !== idx) begin
            errors++;
            $display("FAIL %s[%0d] out_idx got %0d want %0d", name, step, out_idx, idx);
        end
        checks++;
        if (pend_count !== cnt) begin
            errors++;
            $display("FAIL %s[%0d] pend_count got %0d want %0d", name, step, pend_count, cnt);
        end
        $display("%s[%0d]: valid=%b idx=%0d count=%0d", name, step, out_valid, out_idx, pend_count);
    endtask

    task automatic cycle(input logic rst, input logic [31:0] req, input logic rdy);
        reset = rst; req_in = req; out_ready = rdy;
        @(posedge clock);
        #1;
        reset = 1'b0; req_in = '0; out_ready = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1; req_in = '0; out_ready = 1'b0;

        // Single pulse on source 4, accepted immediately.
        add(1, 32'h0, 0, 0, 0, 0);
        add(0, 32'h0000_0010, 1, 0, 0, 1);
        add(0, 32'h0, 1, 1, 4, 1);
        add(0, 32'h0, 1, 0, 4, 0);
        // Three sources including index 31, back-to-back grants.
        add(1, 32'h0, 0, 0, 0, 0);
        add(0, 32'h8000_0005, 1, 0, 0, 3);
`ifdef ROUND_ROBIN_EN
        add(0, 32'h0, 1, 1, 2, 3);
        add(0, 32'h0, 1, 1, 31, 2);
        add(0, 32'h0, 1, 1, 0, 1);
        add(0, 32'h0, 1, 0, 0, 0);
`else
        add(0, 32'h0, 1, 1, 0, 3);
        add(0, 32'h0, 1, 1, 2, 2);
        add(0, 32'h0, 1, 1, 31, 1);
        add(0, 32'h0, 1, 0, 31, 0);
`endif
        // Accept of 9 with a new request on 9: 12 next, then 9 again.
        add(1, 32'h0, 0, 0, 0, 0);
        add(0, 32'h0000_1200, 0, 0, 0, 2);
        add(0, 32'h0, 0, 1, 9, 2);
        add(0, 32'h0000_0200, 1, 1, 12, 2);
        add(0, 32'h0, 1, 1, 9, 1);
        add(0, 32'h0, 1, 0, 9, 0);
        // Sources 1 and 5 held high: the presented index is excluded, so grants alternate.
        add(1, 32'h0, 0, 0, 0, 0);
        add(0, 32'h0000_0022, 1, 0, 0, 2);
        add(0, 32'h0000_0022, 1, 1, 1, 2);
        add(0, 32'h0000_0022, 1, 1, 5, 2);
        add(0, 32'h0000_0022, 1, 1, 1, 2);
        add(0, 32'h0000_0022, 1, 1, 5, 2);
        add(0, 32'h0, 1, 1, 1, 1);
        add(0, 32'h0, 1, 0, 1, 0);
        // Grant 5 first, then {2,7} from idle: priority mode decides the order.
        add(1, 32'h0, 0, 0, 0, 0);
        add(0, 32'h0000_0020, 1, 0, 0, 1);
        add(0, 32'h0, 1, 1, 5, 1);
        add(0, 32'h0, 1, 0, 5, 0);
        add(0, 32'h0000_0084, 1, 0, 5, 2);
`ifdef ROUND_ROBIN_EN
        add(0, 32'h0, 1, 1, 7, 2);
        add(0, 32'h0, 1, 1, 2, 1);
        add(0, 32'h0, 1, 0, 2, 0);
`else
        add(0, 32'h0, 1, 1, 2, 2);
        add(0, 32'h0, 1, 1, 7, 1);
        add(0, 32'h0, 1, 0, 7, 0);
`endif
        // All 32 pending, then reset during a live handshake.
        add(1, 32'h0, 0, 0, 0, 0);
        add(0, 32'hFFFF_FFFF, 0, 0, 0, 32);
`ifdef ROUND_ROBIN_EN
        add(0, 32'h0, 0, 1, 1, 32);
`else
        add(0, 32'h0, 0, 1, 0, 32);
`endif
        add(1, 32'h0, 1, 0, 0, 0);
        add(0, 32'h0, 1, 0, 0, 0);

        // Reset then idle for 10 cycles.
        cycle(1, 32'h0, 0);
        check("reset", 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cycle(0, 32'h0, 1);
            check("idle", i, 0, 0, 0);
        end

        // Table-driven vectors.
        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].rst, vecs[i].req, vecs[i].rdy);
            check("vec", i, vecs[i].exp_valid, vecs[i].exp_idx, vecs[i].exp_count);
        end

        // Backpressure: {3,7} pending, consumer stalls 5 cycles.
        cycle(1, 32'h0, 0);
        cycle(0, 32'h0000_0088, 0);
        check("bp_cap", 0, 0, 0, 2);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 32'h0, 0);
            check("bp_hold", i, 1, 3, 2);
        end
        cycle(0, 32'h0, 1);
        check("bp_rel", 0, 1, 7, 1);
        cycle(0, 32'h0, 1);
        check("bp_rel", 1, 0, 7, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
